// File: rtl/cpu_dbus_ctrl.sv
// cpu_dbus_ctrl: routes cpu data accesses to data RAM, the peripheral bus or unmapped space,
// with one outstanding peripheral access, an ack timeout and a pipelined RAM path.
module cpu_dbus_ctrl #(
    parameter int         RAM_ADDR_BITS = 14,
    parameter logic [3:0] PERIPH_NIBBLE = 4'hE,
    parameter int         TIMEOUT       = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_request,
    input  logic [31:0]              cpu_address,
    input  logic                     cpu_write,
    input  logic [3:0]               cpu_wstrb,
    input  logic [31:0]              cpu_wdata,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_mem_busy,
    output logic                     cpu_valid,
    output logic                     ram_en,
    output logic [RAM_ADDR_BITS-3:0] ram_addr,
    output logic [3:0]               ram_wstrb,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata,
    output logic                     per_request,
    output logic [31:0]              per_address,
    output logic                     per_write,
    output logic [3:0]               per_wstrb,
    output logic [31:0]              per_wdata,
    input  logic [31:0]              per_rdata,
    input  logic                     per_ack,
    output logic                     bus_error
);
    typedef enum logic {IDLE, PER_WAIT} state_t;
    state_t      state, state_d;
    logic [15:0] wait_cnt, wait_cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        valid_q, valid_d, err_q, err_d, ram_rd_q;
    logic        accept, is_ram, is_per, timeout;
    assign is_ram       = cpu_address[31:RAM_ADDR_BITS] == '0;
    assign is_per       = !is_ram && cpu_address[31:28] == PERIPH_NIBBLE;
    assign cpu_mem_busy = state == PER_WAIT;
    assign per_request  = state == PER_WAIT;
    assign accept       = cpu_request && !cpu_mem_busy && !reset;
    assign ram_en       = accept && is_ram;
    assign ram_addr     = cpu_address[RAM_ADDR_BITS-1:2];
    assign ram_wstrb    = (ram_en && cpu_write) ? cpu_wstrb : 4'h0;
    assign ram_wdata    = cpu_wdata;
    // the last wait cycle is the one in which the counter would reach TIMEOUT
    assign timeout      = wait_cnt == 16'(TIMEOUT - 1);
    // RAM read data is passed straight through in the cycle after the strobe
    assign cpu_valid    = ram_rd_q || valid_q;
    assign cpu_rdata    = ram_rd_q ? ram_rdata : rdata_q;
    assign bus_error    = err_q;
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        if (state == IDLE) begin
            wait_cnt_d = '0;
            if (accept && is_per) begin
                state_d = PER_WAIT;
            end else if (accept && !is_ram) begin
                valid_d = !cpu_write;
                err_d   = 1'b1;
                rdata_d = cpu_write ? rdata_q : 32'h0;
            end
        end else begin
            wait_cnt_d = wait_cnt + 16'd1;
            if (per_ack) begin
                state_d = IDLE;
                valid_d = !per_write;
                rdata_d = per_write ? rdata_q : per_rdata;
            end else if (timeout) begin
                state_d = IDLE;
                valid_d = !per_write;
                err_d   = 1'b1;
                rdata_d = per_write ? rdata_q : 32'h0;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            ram_rd_q    <= 1'b0;
            rdata_q     <= '0;
            per_address <= '0;
            per_write   <= 1'b0;
            per_wstrb   <= '0;
            per_wdata   <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ram_rd_q <= ram_en && !cpu_write;
            rdata_q  <= rdata_d;
            if (accept && is_per) begin
                per_address <= cpu_address;
                per_write   <= cpu_write;
                per_wstrb   <= cpu_wstrb;
                per_wdata   <= cpu_wdata;
            end
        end
    end
endmodule

// File: tb/tb_cpu_dbus_ctrl.sv
// tb_cpu_dbus_ctrl: directed and random cpu traffic against a transaction-level model
// that schedules expected responses by cycle number; the bench also plays RAM and peripheral.
module tb_cpu_dbus_ctrl;
    localparam int TO = 255;
    localparam int NC = 20000;
    logic        clock = 0, reset = 1, cpu_request = 0, cpu_write = 0, per_ack = 0;
    logic [31:0] cpu_address = 0, cpu_wdata = 0, per_rdata = 0, ram_rdata;
    logic [3:0]  cpu_wstrb = 0;
    logic [31:0] cpu_rdata, ram_wdata, per_address, per_wdata;
    logic        cpu_mem_busy, cpu_valid, ram_en, per_request, per_write, bus_error;
    logic [11:0] ram_addr;
    logic [3:0]  ram_wstrb, per_wstrb;
    always #5 clock = ~clock;

    cpu_dbus_ctrl dut (
        .clock(clock), .reset(reset), .cpu_request(cpu_request), .cpu_address(cpu_address),
        .cpu_write(cpu_write), .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_mem_busy(cpu_mem_busy), .cpu_valid(cpu_valid), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .per_request(per_request), .per_address(per_address), .per_write(per_write),
        .per_wstrb(per_wstrb), .per_wdata(per_wdata), .per_rdata(per_rdata), .per_ack(per_ack),
        .bus_error(bus_error)
    );

    bit [31:0] bmem [0:4095];
    bit [31:0] ref_mem [0:4095];
    bit        ev [0:NC-1];
    bit        ee [0:NC-1];
    bit [31:0] ed [0:NC-1];
    int        cyc = -1, busy_end = 0, ack_cycle = -1, plan_d = -1, checks = 0, errors = 0;
    logic [31:0] ack_data = 0, plan_data = 0, lat_a = 0, lat_d = 0;
    logic [3:0]  lat_s = 0;
    logic        lat_w = 0;
    bit          last_acc = 1;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // behaves as the synchronous data RAM the controller drives
    always @(posedge clock)
        if (ram_en) begin
            ram_rdata      <= bmem[ram_addr];
            bmem[ram_addr] <= (bmem[ram_addr] & ~strb_mask(ram_wstrb)) | (ram_wdata & strb_mask(ram_wstrb));
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        if (a[31:14] == 18'd0) return 0;
        if (a[31:28] == 4'hE) return 1;
        return 2;
    endfunction

    function automatic int pick_delay();
        int r = $urandom_range(0, 9);
        return r == 0 ? 0 : r == 1 ? TO : int'($urandom_range(1, 6));
    endfunction

    task automatic step(input bit rq, input logic [31:0] a, input bit w, input logic [3:0] s,
                        input logic [31:0] d, input bit rs);
        bit busy, acc;
        int rg, dl;
        @(posedge clock);
        #1;
        cyc++;
        reset = rs; cpu_request = rq; cpu_address = a; cpu_write = w; cpu_wstrb = s; cpu_wdata = d;
        busy = cyc < busy_end;
        per_ack   = (cyc == ack_cycle) || (!busy && $urandom_range(0, 3) == 0);
        per_rdata = (cyc == ack_cycle) ? ack_data : $urandom;
        #1;
        acc = rq && !busy && !rs;
        rg  = region(a);
        check("busy", 32'(cpu_mem_busy), 32'(busy));
        check("per_request", 32'(per_request), 32'(busy));
        check("valid", 32'(cpu_valid), 32'(ev[cyc]));
        if (ev[cyc]) check("rdata", cpu_rdata, ed[cyc]);
        check("bus_error", 32'(bus_error), 32'(ee[cyc]));
        check("ram_en", 32'(ram_en), 32'(acc && rg == 0));
        if (acc && rg == 0) begin
            check("ram_addr", 32'(ram_addr), 32'(a[13:2]));
            check("ram_wstrb", 32'(ram_wstrb), w ? 32'(s) : 32'd0);
            if (w) check("ram_wdata", ram_wdata, d);
        end
        if (busy) begin
            check("per_address", per_address, lat_a);
            check("per_write", 32'(per_write), 32'(lat_w));
            check("per_wstrb", 32'(per_wstrb), 32'(lat_s));
            check("per_wdata", per_wdata, lat_d);
        end
        last_acc = acc;
        if (acc && rg == 0) begin
            if (w) ref_mem[a[13:2]] = (ref_mem[a[13:2]] & ~strb_mask(s)) | (d & strb_mask(s));
            else begin ev[cyc+1] = 1; ed[cyc+1] = ref_mem[a[13:2]]; end
        end else if (acc && rg == 1) begin
            lat_a = a; lat_w = w; lat_s = s; lat_d = d;
            dl = plan_d >= 0 ? plan_d : pick_delay();
            ack_data = plan_d >= 0 ? plan_data : $urandom;
            plan_d = -1;
            if (dl == 0) begin
                ack_cycle = -1;
                busy_end = cyc + TO + 1;
                ee[busy_end] = 1;
                if (!w) begin ev[busy_end] = 1; ed[busy_end] = 0; end
            end else begin
                ack_cycle = cyc + dl;
                busy_end = ack_cycle + 1;
                if (!w) begin ev[busy_end] = 1; ed[busy_end] = ack_data; end
            end
        end else if (acc) begin
            ee[cyc+1] = 1;
            if (!w) begin ev[cyc+1] = 1; ed[cyc+1] = 0; end
        end
        if (rs) begin
            busy_end = cyc + 1;
            ack_cycle = -1;
            for (int k = cyc + 1; k < NC; k++) begin ev[k] = 0; ee[k] = 0; end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, $urandom, 0, 4'h0, 32'h0, 0);
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            3:       return 32'h3FFC | 32'($urandom_range(0, 3));
            4, 5:    return {4'hE, 28'($urandom)};
            6:       return 32'h4000 + 32'($urandom_range(0, 255));
            default: return {4'h8, 28'($urandom)};
        endcase
    endfunction

    initial begin
        bit rq = 0, w = 0;
        logic [31:0] a = 0, d = 0;
        logic [3:0] s = 0;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("reset_rdata", cpu_rdata, 32'h0);
        check("reset_per_address", per_address, 32'h0);
        check("reset_per_wdata", per_wdata, 32'h0);
        check("reset_per_wstrb", 32'(per_wstrb), 32'h0);
        step(1, 32'h100, 1, 4'hF, 32'h12345678, 0);
        step(1, 32'h100, 0, 4'h0, 32'h0, 0);
        idle(1);
        check("ram_word_read", cpu_rdata, 32'h12345678);
        step(1, 32'h100, 1, 4'b0010, 32'h0000AB00, 0);
        step(1, 32'h100, 0, 4'h0, 32'h0, 0);
        idle(1);
        check("ram_byte_read", cpu_rdata, 32'h1234AB78);
        for (int i = 1; i < 4; i++) step(1, 32'h100 + 32'(4 * i), 1, 4'hF, 32'hA0A0_0000 + 32'(i), 0);
        for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(4 * i), 0, 4'h0, 32'h0, 0);
        idle(1);
        check("burst_last", cpu_rdata, 32'hA0A0_0003);
        plan_d = 3; plan_data = 32'hCAFEF00D;
        step(1, 32'hE000_0010, 0, 4'h0, 32'h0, 0);
        idle(4);
        check("per_read_data", cpu_rdata, 32'hCAFEF00D);
        plan_d = 0;
        step(1, 32'hE000_0020, 0, 4'h0, 32'h0, 0);
        idle(TO + 1);
        check("timeout_error", 32'(bus_error), 32'h1);
        check("timeout_rdata", cpu_rdata, 32'h0);
        idle(2);
        plan_d = 0;
        step(1, 32'hE000_0030, 0, 4'h0, 32'h0, 0);
        idle(5);
        step(0, 32'h0, 0, 4'h0, 32'h0, 1);
        idle(1);
        check("reset_wait_per_request", 32'(per_request), 32'h0);
        idle(TO + 5);
        step(1, 32'h8000_0000, 0, 4'h0, 32'h0, 0);
        idle(1);
        check("unmapped_error", 32'(bus_error), 32'h1);
        step(1, 32'h8000_0000, 1, 4'hF, 32'hDEADBEEF, 0);
        idle(2);
        step(1, 32'h3FFC, 1, 4'hF, 32'h0BADF00D, 0);
        step(1, 32'h3FFC, 0, 4'h0, 32'h0, 0);
        step(1, 32'h4000, 0, 4'h0, 32'h0, 0);
        idle(2);
        plan_d = TO; plan_data = 32'h5A5A_1234;
        step(1, 32'hE000_0040, 0, 4'h0, 32'h0, 0);
        idle(TO + 2);
        plan_d = 2; plan_data = 32'h0;
        step(1, 32'hE000_0100, 1, 4'h5, 32'h55AA55AA, 0);
        idle(4);
        step(1, 32'h104, 0, 4'h0, 32'h0, 0);
        plan_d = 1; plan_data = 32'h1357_9BDF;
        step(1, 32'hE000_0004, 0, 4'h0, 32'h0, 0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            if (last_acc || !rq) begin
                rq = $urandom_range(0, 3) != 0;
                a = rnd_addr();
                w = 1'($urandom_range(0, 1));
                s = 4'($urandom);
                d = $urandom;
            end
            step(rq, a, w, s, d, 0);
        end
        idle(TO + 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
